// File: rtl/mul_dec_scheduler.sv
// rtl/mul_dec_scheduler.sv - packs mixed-precision multiply requests onto a shared decomposable 32x32 multiplier
//
// pe_pkg          : precision mode encodings shared with the PE datapath.
// mul_dec_32x32   : combinational 32x32 multiplier built from 16 8x8 partial
//                   products; mode selects which partials contribute so one
//                   array yields 1x64b, 2x32b or 4x16b products.
// mul_dec_scheduler ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        request handshake (in_ready combinational on in_mode)
//   in_mode, in_a, in_b      precision and LSB-aligned operands
//   in_tag                   request tag, returned with its product
//   in_flush                 force issue of a partially filled pack buffer
//   out_valid/out_ready      packed result handshake
//   out_mode, out_count      precision and number of valid slots of the issue
//   out_data, out_tags       packed products and per-slot tags (unused slots 0)
//   busy                     pack buffer or any pipeline stage occupied
//   err_mode                 sticky flag for accepted requests with illegal mode

package pe_pkg;
    localparam int PRECISION_CONFIG_L = 2;
    localparam logic [PRECISION_CONFIG_L-1:0] PRECISION_CONFIG_32B = 2'd0;
    localparam logic [PRECISION_CONFIG_L-1:0] PRECISION_CONFIG_16B = 2'd1;
    localparam logic [PRECISION_CONFIG_L-1:0] PRECISION_CONFIG_8B  = 2'd2;
endpackage

module mul_dec_32x32 (
    input  logic [pe_pkg::PRECISION_CONFIG_L-1:0] mode,
    input  logic [31:0]                           a,
    input  logic [31:0]                           b,
    output logic [63:0]                           p
);
    import pe_pkg::*;

    logic [15:0] pp;
    logic        en;

    // Partial a_byte[i]*b_byte[j] carries weight 2^(8*(i+j)). Keeping only the
    // partials inside one lane leaves each lane's product at its packed
    // position: halves land at bit 0/32, quarters at bit 16*k.
    always_comb begin
        p  = '0;
        pp = '0;
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                pp = a[8*i +: 8] * b[8*j +: 8];
                case (mode)
                    PRECISION_CONFIG_32B: en = 1'b1;
                    PRECISION_CONFIG_16B: en = ((i / 2) == (j / 2));
                    PRECISION_CONFIG_8B:  en = (i == j);
                    default:              en = 1'b0;
                endcase
                if (en) begin
                    p = p + ({48'd0, pp} << (8 * (i + j)));
                end
            end
        end
    end
endmodule

module mul_dec_scheduler #(
    parameter int TAG_W         = 6,
    parameter int FLUSH_TIMEOUT = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [pe_pkg::PRECISION_CONFIG_L-1:0] in_mode,
    input  logic [31:0]                           in_a,
    input  logic [31:0]                           in_b,
    input  logic [TAG_W-1:0]                      in_tag,
    input  logic                                  in_flush,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [pe_pkg::PRECISION_CONFIG_L-1:0] out_mode,
    output logic [2:0]                            out_count,
    output logic [63:0]                           out_data,
    output logic [4*TAG_W-1:0]                    out_tags,
    output logic                                  busy,
    output logic                                  err_mode
);
    import pe_pkg::*;

    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_STALL} state_t;

    localparam logic [7:0] TIMEOUT_V = 8'(FLUSH_TIMEOUT);

    state_t state_q, state_d;

    // pack buffer
    logic [PRECISION_CONFIG_L-1:0] buf_mode, buf_mode_d;
    logic [2:0]                    buf_count, buf_count_d, base_count;
    logic [31:0]                   buf_a, buf_a_d, buf_b, buf_b_d;
    logic [4*TAG_W-1:0]            buf_tags, buf_tags_d;
    logic [31:0]                   a_lane, b_lane;
    logic [4*TAG_W-1:0]            tag_lane;
    logic [7:0]                    idle_cnt;
    logic                          rst_q;
    logic                          err_q;

    // stage 1: operands feeding the multiplier
    logic                          s1_valid;
    logic [PRECISION_CONFIG_L-1:0] s1_mode;
    logic [2:0]                    s1_count;
    logic [31:0]                   s1_a, s1_b;
    logic [4*TAG_W-1:0]            s1_tags;

    // stage 2: registered products
    logic                          s2_valid;
    logic [PRECISION_CONFIG_L-1:0] s2_mode;
    logic [2:0]                    s2_count;
    logic [63:0]                   s2_data;
    logic [4*TAG_W-1:0]            s2_tags;

    logic [63:0] mul_p;

    logic mode_legal, buf_nonempty, buf_full, mode_conflict, timeout_hit;
    logic issue_cond, issue_fire, s1_advance, s1_free;
    logic accept, accept_op;

    function automatic logic [2:0] cap_of(input logic [PRECISION_CONFIG_L-1:0] m);
        case (m)
            PRECISION_CONFIG_16B: return 3'd2;
            PRECISION_CONFIG_8B:  return 3'd4;
            default:              return 3'd1;
        endcase
    endfunction

    mul_dec_32x32 u_mul (
        .mode (s1_mode),
        .a    (s1_a),
        .b    (s1_b),
        .p    (mul_p)
    );

    assign mode_legal    = (in_mode == PRECISION_CONFIG_32B) ||
                           (in_mode == PRECISION_CONFIG_16B) ||
                           (in_mode == PRECISION_CONFIG_8B);
    assign buf_nonempty  = (buf_count != 3'd0);
    assign buf_full      = (buf_count == cap_of(buf_mode));
    // An illegal request is dropped without touching the buffer, so it never
    // forces the current pack out.
    assign mode_conflict = buf_nonempty && in_valid && mode_legal && (in_mode != buf_mode);
    assign timeout_hit   = buf_nonempty && (idle_cnt == TIMEOUT_V);
    assign issue_cond    = buf_full || mode_conflict || timeout_hit || (in_flush && buf_nonempty);
    assign s1_advance    = !s2_valid || out_ready;
    assign s1_free       = !s1_valid || s1_advance;
    assign issue_fire    = issue_cond && s1_free;

    // rst_q keeps the request port closed for the first cycle after reset.
    assign in_ready  = !rst && !rst_q && ((!buf_full && !mode_conflict) || issue_fire);
    assign accept    = in_valid && in_ready;
    assign accept_op = accept && mode_legal;

    always_comb begin
        // An issuing buffer is vacated this cycle, so a same-cycle accept
        // starts over at slot 0.
        base_count  = issue_fire ? 3'd0 : buf_count;
        buf_a_d     = issue_fire ? 32'd0 : buf_a;
        buf_b_d     = issue_fire ? 32'd0 : buf_b;
        buf_tags_d  = issue_fire ? '0 : buf_tags;
        buf_mode_d  = buf_mode;
        buf_count_d = base_count;
        a_lane      = '0;
        b_lane      = '0;
        case (in_mode)
            PRECISION_CONFIG_32B: begin
                a_lane = in_a;
                b_lane = in_b;
            end
            PRECISION_CONFIG_16B: begin
                a_lane = {16'd0, in_a[15:0]} << {base_count[0], 4'd0};
                b_lane = {16'd0, in_b[15:0]} << {base_count[0], 4'd0};
            end
            PRECISION_CONFIG_8B: begin
                a_lane = {24'd0, in_a[7:0]} << {base_count[1:0], 3'd0};
                b_lane = {24'd0, in_b[7:0]} << {base_count[1:0], 3'd0};
            end
            default: begin
                a_lane = '0;
                b_lane = '0;
            end
        endcase
        tag_lane = {{(3*TAG_W){1'b0}}, in_tag} << (TAG_W * int'(base_count[1:0]));
        if (accept_op) begin
            buf_mode_d  = in_mode;
            buf_count_d = base_count + 3'd1;
            buf_a_d     = buf_a_d | a_lane;
            buf_b_d     = buf_b_d | b_lane;
            buf_tags_d  = buf_tags_d | tag_lane;
        end

        if (buf_count_d == 3'd0) begin
            state_d = ST_IDLE;
        end else if (issue_cond && !issue_fire) begin
            state_d = ST_STALL;
        end else begin
            state_d = ST_FILL;
        end
    end

    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            state_q   <= ST_IDLE;
            buf_mode  <= PRECISION_CONFIG_32B;
            buf_count <= 3'd0;
            buf_a     <= '0;
            buf_b     <= '0;
            buf_tags  <= '0;
            idle_cnt  <= '0;
            err_q     <= 1'b0;
            s1_valid  <= 1'b0;
            s1_mode   <= PRECISION_CONFIG_32B;
            s1_count  <= 3'd0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_tags   <= '0;
            s2_valid  <= 1'b0;
            s2_mode   <= PRECISION_CONFIG_32B;
            s2_count  <= 3'd0;
            s2_data   <= '0;
            s2_tags   <= '0;
        end else begin
            state_q   <= state_d;
            buf_mode  <= buf_mode_d;
            buf_count <= buf_count_d;
            buf_a     <= buf_a_d;
            buf_b     <= buf_b_d;
            buf_tags  <= buf_tags_d;

            if (issue_fire || accept_op) begin
                idle_cnt <= '0;
            end else if (buf_nonempty && (idle_cnt != 8'hFF)) begin
                idle_cnt <= idle_cnt + 8'd1;
            end

            if (accept && !mode_legal) begin
                err_q <= 1'b1;
            end

            if (issue_fire) begin
                s1_valid <= 1'b1;
                s1_mode  <= buf_mode;
                s1_count <= buf_count;
                s1_a     <= buf_a;
                s1_b     <= buf_b;
                s1_tags  <= buf_tags;
            end else if (s1_advance) begin
                s1_valid <= 1'b0;
            end

            // Empty slots carry zero operands, so their product lanes are
            // already zero in mul_p.
            if (s1_advance) begin
                s2_valid <= s1_valid;
                s2_mode  <= s1_mode;
                s2_count <= s1_valid ? s1_count : 3'd0;
                s2_data  <= s1_valid ? mul_p : 64'd0;
                s2_tags  <= s1_valid ? s1_tags : '0;
            end
        end
    end

    assign out_valid = s2_valid;
    assign out_mode  = s2_mode;
    assign out_count = s2_count;
    assign out_data  = s2_data;
    assign out_tags  = s2_tags;
    assign busy      = (state_q != ST_IDLE) || s1_valid || s2_valid;
    assign err_mode  = err_q;
endmodule

// File: doc/mul_dec_scheduler.md
Name: mul_dec_scheduler

Overview:
- Packs a stream of independent multiply requests of mixed precision (32b, 16b, 8b) into issues of the shared decomposable 32x32 multiplier (4 parts x 8 bits).
- One 32b op, up to two 16b ops, or up to four 8b ops go out per issue.
- The block instantiates the multiplier, drives its mode, and returns packed products with per-slot tags through a two-stage valid/ready pipeline.
- It sits between the PE operand-fetch stream and the posit normalisation stage.

Parameters:
- TAG_W, 6: width of the per-request tag, returned unchanged with its result.
- FLUSH_TIMEOUT, 4: consecutive no-accept cycles before a partially filled pack buffer is issued; legal range 1..255.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active high
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- in_mode  in  PRECISION_CONFIG_L  pe_pkg::PRECISION_CONFIG_32B/16B/8B
- in_a  in  32  operand A, LSB-aligned; bits above op width ignored
- in_b  in  32  operand B, LSB-aligned; bits above op width ignored
- in_tag  in  TAG_W  request tag
- in_flush  in  1  force issue of a partial buffer
- out_valid  out  1  packed result valid
- out_ready  in  1  consumer ready
- out_mode  out  PRECISION_CONFIG_L  mode of the issue
- out_count  out  3  valid slots, 1..4
- out_data  out  64  products: full [63:0]; half k at [32k+:32]; quarter k at [16k+:16]
- out_tags  out  4*TAG_W  tag of slot k at [k*TAG_W+:TAG_W]; unused slots 0
- busy  out  1  any buffer or stage occupied
- err_mode  out  1  sticky; set on an accepted request with an illegal in_mode

Behaviour:
- Reset: while rst is high, and on the cycle after, all of the following are 0: in_ready, out_valid, out_data, out_tags, out_count, busy, err_mode. Pack buffer is emptied, FSM goes to IDLE, idle counter is cleared. Reset mid-operation discards all in-flight ops with no output.
- Slot capacity: 32B = 1, 16B = 2, 8B = 4.
- Slot placement: slot k of a 16b op occupies halfword k of both operands; slot k of an 8b op occupies byte k. Unused slot bytes are zero.
- FSM states:
  - IDLE: buffer empty.
  - FILL: buffer partial or full.
  - STALL: issue required but stage 1 cannot accept.
- Issue condition, evaluated on registered buffer state:
  - count == capacity, or
  - buffer nonempty and in_valid with in_mode differing from the buffer mode, or
  - idle counter == FLUSH_TIMEOUT, or
  - in_flush with buffer nonempty.
- issue_fire = issue condition & stage-1 free-or-advancing. Stage 1 advances when stage 2 is empty or out_ready is high.
- in_ready = !rst & ((buffer not full & no mode conflict) | issue_fire). in_ready is combinational on in_mode.
- An accept in the same cycle as issue_fire lands in slot 0 of the fresh buffer. Sustained 32b throughput is 1 op/cycle.
- Illegal mode: the request is accepted and dropped, err_mode is set, and buffer state is unchanged.
- Idle counter: cleared on accept or issue; increments each cycle the buffer is nonempty and nothing is accepted; saturates.
- Stage 1 registers: operands, mode, count, tags. The multiplier is combinational off stage 1.
- Stage 2 registers the multiplier output selected by mode:
  - full output for 32B;
  - {half1, half0} for 16B;
  - the four quarters for 8B.
  - Unused slots read as 0.
- Latency: 3 cycles from the cycle the buffer-filling op is accepted to out_valid (buffer issues t+1, stage 1 t+2, out_valid t+3), with out_ready held high.
- Output handshake: out_valid stays high and out_* stay stable until out_ready. Backpressure propagates stage 2 → stage 1 → buffer → in_ready. No op is lost or duplicated.
- in_flush with an empty buffer: no effect.
- in_flush with simultaneous accept: the buffer issues first; the new op starts a fresh buffer.

Test Plan:
- Four 8b reqs a=3,5,7,255, b=2,4,6,255, tags 1..4, back to back -> one output 3 cycles after the 4th accept: mode 8B, count 4, out_data[15:0]=6, [31:16]=20, [47:32]=42, [63:48]=65025, tags {4,3,2,1}.
- 32b req a=0xFFFFFFFF, b=0xFFFFFFFF, then 32b a=0x10000, b=0x10000 -> two outputs on consecutive cycles: 0xFFFFFFFE00000001, then 0x0000000100000000, each count 1.
- One 16b req a=300, b=200, then idle -> issue after FLUSH_TIMEOUT=4 idle cycles: count 1, out_data[31:0]=60000, [63:32]=0.
- 16b req (a=2, b=3) then 8b req (a=4, b=5) -> mode conflict forces two issues: 16B count 1 product 6; 8B count 1 product 20; order preserved.
- out_ready held low 10 cycles while streaming 8b reqs -> in_ready drops once stage 2, stage 1 and buffer are full; no result lost after release; each product matches its tag.
- rst asserted while stage 1 and stage 2 hold data -> next cycle out_valid=0, busy=0. A request with in_mode=illegal -> err_mode=1 and no output.
